frog_move_controller: RTL

Sequences the frog-position register bank in FROGGER. It turns player button presses into single-cycle shift/row commands and gates horizontal moves using the 2-bit side-location code from the side comparator. It also gates vertical moves using the current frog row. It handles cooldown, death/respawn and goal detection, and sits between the input debouncers and the frog matrix registers.

---
 rtl/frog_pkg.sv | 21 ++
 rtl/frog_tick_counter.sv | 27 ++
 rtl/frog_move_controller.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/frog_pkg.sv
// frog_pkg: shared state/command types, side-location codes and button indices for the frog move controller
package frog_pkg;

    typedef enum logic [1:0] {ARMED, MOVE, COOL, DEAD} state_t;

    typedef enum logic [2:0] {CMD_NONE, CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT} cmd_t;

    localparam logic [1:0] LOC_RIGHT_EDGE = 2'b01;
    localparam logic [1:0] LOC_LEFT_EDGE  = 2'b10;
    localparam logic [1:0] LOC_INTERIOR   = 2'b11;

    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 0;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return v + 8'(v != 8'hFF);
    endfunction

endpackage

// File: rtl/frog_tick_counter.sv
// frog_tick_counter: loadable game-tick down-counter; done flags the tick that expires the count
module frog_tick_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         done
);

    logic [W-1:0] cnt;

    assign done = tick && cnt <= W'(1);

    // load has priority so a fresh interval never loses its first tick to a stale count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (tick && cnt != '0)
            cnt <= cnt - W'(1);
    end

endmodule

// File: rtl/frog_move_controller.sv
// frog_move_controller: button-to-move sequencer with cooldown, death/respawn and goal detection; FROG_MOVE_AUTOREPEAT_EN adds held-button repeat
module frog_move_controller
    import frog_pkg::*;
#(
    parameter int ROWS           = 14,
    parameter int ROWWIDTH       = 4,
    parameter int COOLDOWN_TICKS = 2,
`ifdef FROG_MOVE_AUTOREPEAT_EN
    parameter int REPEAT_TICKS   = 3,
`endif
    parameter int RESPAWN_TICKS  = 4
) (
    input  logic                CC_FROG_MOVE_CLOCK_50,
    input  logic                CC_FROG_MOVE_RESET_InLow,
    input  logic                CC_FROG_MOVE_TICK_In,
    input  logic [3:0]          CC_FROG_MOVE_BTN_In_Bus,
    input  logic [1:0]          CC_FROG_MOVE_LOCATION_In_Bus,
    input  logic [ROWWIDTH-1:0] CC_FROG_MOVE_ROW_In_Bus,
    input  logic                CC_FROG_MOVE_COLLISION_In,
    output logic                CC_FROG_MOVE_SHIFT_LEFT_Out,
    output logic                CC_FROG_MOVE_SHIFT_RIGHT_Out,
    output logic                CC_FROG_MOVE_ROW_UP_Out,
    output logic                CC_FROG_MOVE_ROW_DOWN_Out,
    output logic                CC_FROG_MOVE_RESPAWN_Out,
    output logic                CC_FROG_MOVE_GOAL_Out,
    output logic                CC_FROG_MOVE_BUSY_Out,
    output logic [7:0]          CC_FROG_MOVE_COUNT_Out_Bus
);

    localparam int TMAX = COOLDOWN_TICKS > RESPAWN_TICKS ? COOLDOWN_TICKS : RESPAWN_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    logic          clk, rst_n, tick, collision;
    logic [1:0]    loc;
    logic [ROWWIDTH-1:0] row;
    logic [3:0]    btn_q, btn_prev, press;
    state_t        state;
    cmd_t          cmd_q, sel;
    logic          legal, go_dead, load, done;
    logic [TW-1:0] load_val;

    assign clk       = CC_FROG_MOVE_CLOCK_50;
    assign rst_n     = CC_FROG_MOVE_RESET_InLow;
    assign tick      = CC_FROG_MOVE_TICK_In;
    assign collision = CC_FROG_MOVE_COLLISION_In;
    assign loc       = CC_FROG_MOVE_LOCATION_In_Bus;
    assign row       = CC_FROG_MOVE_ROW_In_Bus;

`ifdef FROG_MOVE_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);

    logic [RW-1:0] rep_cnt;
    logic          held, rep_fire;

    assign held     = state == ARMED && btn_q != 4'b0 && btn_q == btn_prev;
    assign rep_fire = held && tick && rep_cnt == RW'(REPEAT_TICKS - 1);
    assign press    = (btn_q & ~btn_prev) | (rep_fire ? btn_q : 4'b0);

    // ticks accumulate only while the same buttons stay held in ARMED; any change restarts the interval
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rep_cnt <= '0;
        else if (!held || rep_fire)
            rep_cnt <= '0;
        else if (tick)
            rep_cnt <= rep_cnt + RW'(1);
    end
`else
    assign press = btn_q & ~btn_prev;
`endif

    assign sel   = press[BTN_UP]    ? CMD_UP    :
                   press[BTN_DOWN]  ? CMD_DOWN  :
                   press[BTN_LEFT]  ? CMD_LEFT  :
                   press[BTN_RIGHT] ? CMD_RIGHT : CMD_NONE;

    // only the highest-priority press is judged; a blocked one does not fall through
    assign legal = press[BTN_UP]    ? row != ROWWIDTH'(ROWS - 1) :
                   press[BTN_DOWN]  ? row != '0 :
                   press[BTN_LEFT]  ? loc == LOC_INTERIOR || loc == LOC_RIGHT_EDGE :
                   press[BTN_RIGHT] ? loc == LOC_INTERIOR || loc == LOC_LEFT_EDGE : 1'b0;

    assign go_dead  = collision && state != DEAD;
    assign load     = go_dead || state == MOVE;
    assign load_val = go_dead ? TW'(RESPAWN_TICKS) : TW'(COOLDOWN_TICKS);

    frog_tick_counter #(.W(TW)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .done     (done)
    );

    // main FSM: commands are registered at the end of MOVE so a collision during MOVE can still cancel them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                        <= ARMED;
            cmd_q                        <= CMD_NONE;
            btn_q                        <= '0;
            btn_prev                     <= '0;
            CC_FROG_MOVE_SHIFT_LEFT_Out  <= 1'b0;
            CC_FROG_MOVE_SHIFT_RIGHT_Out <= 1'b0;
            CC_FROG_MOVE_ROW_UP_Out      <= 1'b0;
            CC_FROG_MOVE_ROW_DOWN_Out    <= 1'b0;
            CC_FROG_MOVE_RESPAWN_Out     <= 1'b0;
            CC_FROG_MOVE_GOAL_Out        <= 1'b0;
            CC_FROG_MOVE_BUSY_Out        <= 1'b0;
            CC_FROG_MOVE_COUNT_Out_Bus   <= '0;
        end else begin
            btn_q                        <= CC_FROG_MOVE_BTN_In_Bus;
            btn_prev                     <= btn_q;
            CC_FROG_MOVE_SHIFT_LEFT_Out  <= 1'b0;
            CC_FROG_MOVE_SHIFT_RIGHT_Out <= 1'b0;
            CC_FROG_MOVE_ROW_UP_Out      <= 1'b0;
            CC_FROG_MOVE_ROW_DOWN_Out    <= 1'b0;
            CC_FROG_MOVE_RESPAWN_Out     <= 1'b0;
            CC_FROG_MOVE_GOAL_Out        <= 1'b0;
            if (go_dead) begin
                state                 <= DEAD;
                CC_FROG_MOVE_BUSY_Out <= 1'b1;
            end else begin
                case (state)
                    ARMED: begin
                        state                 <= legal ? MOVE : ARMED;
                        cmd_q                 <= legal ? sel : cmd_q;
                        CC_FROG_MOVE_BUSY_Out <= legal;
                    end
                    MOVE: begin
                        CC_FROG_MOVE_SHIFT_LEFT_Out  <= cmd_q == CMD_LEFT;
                        CC_FROG_MOVE_SHIFT_RIGHT_Out <= cmd_q == CMD_RIGHT;
                        CC_FROG_MOVE_ROW_UP_Out      <= cmd_q == CMD_UP;
                        CC_FROG_MOVE_ROW_DOWN_Out    <= cmd_q == CMD_DOWN;
                        CC_FROG_MOVE_GOAL_Out        <= cmd_q == CMD_UP && row == ROWWIDTH'(ROWS - 2);
                        CC_FROG_MOVE_COUNT_Out_Bus   <= sat_inc(CC_FROG_MOVE_COUNT_Out_Bus);
                        CC_FROG_MOVE_BUSY_Out        <= 1'b1;
                        state                        <= COOL;
                    end
                    COOL: begin
                        state                 <= done ? ARMED : COOL;
                        CC_FROG_MOVE_BUSY_Out <= !done;
                    end
                    default: begin
                        state                    <= done ? ARMED : DEAD;
                        CC_FROG_MOVE_RESPAWN_Out <= done;
                        CC_FROG_MOVE_BUSY_Out    <= !done;
                    end
                endcase
            end
        end
    end

endmodule
